// File: rtl/fx_div_iter.sv
// fx_div_iter: iterative signed fixed-point divider, one quotient bit per cycle.
// Optional FXDIV_ROUND_EN: round half away from zero instead of truncating.
module fx_div_iter #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int QFRAC = WIDTH - QINT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             dz,
  output logic             ovf
);

  localparam int ITER = WIDTH + QFRAC;
  localparam int CW = $clog2(ITER);
  localparam logic [ITER:0] LIM = (ITER+1)'(1) << (WIDTH-1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t st, nxt;
  logic load, step, fin;

  logic            sgn, nneg;
  logic [ITER-1:0] dvd, quo;
  logic [WIDTH-1:0] den_mag, rem;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] num_abs, den_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge, rnd, zden, pos_ovf, neg_ovf;
  logic [ITER:0]    mag;
  logic [WIDTH-1:0] res_fin;

  // operand magnitudes and one restoring step
  assign num_abs = numerator[WIDTH-1] ? -numerator : numerator;
  assign den_abs = denominator[WIDTH-1] ? -denominator : denominator;
  assign rem_sh = {rem, dvd[ITER-1]};
  assign ge = rem_sh >= {1'b0, den_mag};
  assign diff = rem_sh - {1'b0, den_mag};

`ifdef FXDIV_ROUND_EN
  assign rnd = {rem, 1'b0} >= {1'b0, den_mag};
`else
  assign rnd = 1'b0;
`endif

  // final magnitude, saturation and special cases
  assign zden = (den_mag == '0);
  assign mag = {1'b0, quo} + (ITER+1)'(rnd);
  assign pos_ovf = !sgn && (mag >= LIM);
  assign neg_ovf = sgn && (mag > LIM);

  // select the value published on done
  always_comb begin
    res_fin = sgn ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    if (zden)
      res_fin = nneg ? MINN : MAXP;
    else if (pos_ovf)
      res_fin = MAXP;
    else if (neg_ovf)
      res_fin = MINN;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  end

  // next state and datapath strobes; FIN may accept a new start
  always_comb begin
    nxt = st;
    load = 1'b0;
    step = 1'b0;
    fin = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == '0) nxt = FIN;
      end
      FIN: begin
        fin = 1'b1;
        nxt = IDLE;
        if (start) begin
          load = 1'b1;
          nxt = CALC;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // operand capture, shift/subtract iterations and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
      nneg <= 1'b0;
      dvd <= '0;
      quo <= '0;
      den_mag <= '0;
      rem <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      dz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sgn <= numerator[WIDTH-1] ^ denominator[WIDTH-1];
        nneg <= numerator[WIDTH-1];
        dvd <= {num_abs, {QFRAC{1'b0}}};
        den_mag <= den_abs;
        rem <= '0;
        quo <= '0;
        cnt <= CW'(ITER-1);
        busy <= 1'b1;
      end else if (step) begin
        dvd <= {dvd[ITER-2:0], 1'b0};
        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo <= {quo[ITER-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == '0) busy <= 1'b0;
      end
      if (fin) begin
        result <= res_fin;
        dz <= zden;
        ovf <= !zden && (pos_ovf || neg_ovf);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fx_div_iter.sv
// tb_fx_div_iter: randomized and directed checks of fx_div_iter
// against an arithmetic reference model.
module tb_fx_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] numerator = '0;
  logic [31:0] denominator = '0;
  logic [31:0] result;
  logic        done, busy, dz, ovf;

  int n_checks = 0;
  int n_fail = 0;

  fx_div_iter dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .numerator(numerator),
    .denominator(denominator),
    .result(result),
    .done(done),
    .busy(busy),
    .dz(dz),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] n, input logic [31:0] d,
                       output logic [31:0] r, output logic z,
                       output logic o);
    longint an, ad, q, rr;
    bit neg;
    an = $signed(n);
    ad = $signed(d);
    neg = (an < 0) != (ad < 0);
    if (an < 0) an = -an;
    if (ad < 0) ad = -ad;
    z = 1'b0;
    o = 1'b0;
    if (ad == 0) begin
      z = 1'b1;
      r = ($signed(n) >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return;
    end
    q = (an * 65536) / ad;
    rr = (an * 65536) % ad;
`ifdef FXDIV_ROUND_EN
    if (2 * rr >= ad) q = q + 1;
`endif
    if (!neg && q > 64'd2147483647) begin
      o = 1'b1;
      r = 32'h7FFF_FFFF;
    end else if (neg && q > 64'd2147483648) begin
      o = 1'b1;
      r = 32'h8000_0000;
    end else begin
      r = neg ? 32'(-q) : 32'(q);
    end
  endtask

  task automatic do_div(input logic [31:0] n, input logic [31:0] d,
                        input bit noise,
                        output logic [31:0] r, output logic z,
                        output logic o, output int lat,
                        output int bcnt, output bit got);
    @(negedge clk);
    numerator = n;
    denominator = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    bcnt = busy ? 1 : 0;
    got = 1'b0;
    r = '0;
    z = 1'b0;
    o = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && i >= 3 && i <= 30) begin
        start = 1'($urandom % 2);
        numerator = $urandom;
        denominator = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        got = 1'b1;
        r = result;
        z = dz;
        o = ovf;
      end else if (busy) begin
        bcnt++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
  } op_t;

  logic [31:0] tn [10];
  logic [31:0] td [10];
  logic [31:0] tr [10];
  logic        tz [10];
  logic        to [10];

  initial begin
    logic [31:0] r, er;
    logic z, o, ez, eo;
    int lat, bcnt, nd, last;
    bit got;
    op_t q[$];
    op_t op;
    int next_acc;

    tn = '{32'h0003_0000, 32'hFFF8_8000, 32'h8000_0000,
           32'h0002_0000, 32'hFFFE_0000, 32'h0005_0000,
           32'hFFFB_0000, 32'h0, 32'h7530_0000, 32'h8AD0_0000};
    td = '{32'h0002_0000, 32'h0002_8000, 32'h0001_0000,
           32'h0003_0000, 32'h0003_0000, 32'h0,
           32'h0, 32'h0, 32'h0000_4000, 32'h0000_4000};
`ifdef FXDIV_ROUND_EN
    tr = '{32'h0001_8000, 32'hFFFD_0000, 32'h8000_0000,
           32'h0000_AAAB, 32'hFFFF_5555, 32'h7FFF_FFFF,
           32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
`else
    tr = '{32'h0001_8000, 32'hFFFD_0000, 32'h8000_0000,
           32'h0000_AAAA, 32'hFFFF_5556, 32'h7FFF_FFFF,
           32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
`endif
    tz = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    to = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {result, done, busy, dz, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_div(tn[i], td[i], i % 2 == 1, r, z, o, lat, bcnt, got);
      check($sformatf("dir%0d_done", i), 64'(got), 64'd1);
      check($sformatf("dir%0d_res", i), 64'(r), 64'(tr[i]));
      check($sformatf("dir%0d_dz", i), 64'(z), 64'(tz[i]));
      check($sformatf("dir%0d_ovf", i), 64'(o), 64'(to[i]));
      check($sformatf("dir%0d_lat", i), 64'(lat), 64'd49);
      check($sformatf("dir%0d_busy", i), 64'(bcnt), 64'd48);
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("hold_done", 64'(done), 64'd0);
        check("hold_res", 64'(result), 64'h0001_8000);
      end
    end

    for (int i = 0; i < 24; i++) begin
      logic [31:0] n, d;
      n = $urandom;
      d = $urandom >> ($urandom % 28);
      if ($urandom % 8 == 0) d = '0;
      if ($urandom % 2 == 0) d = -d;
      if ($urandom % 10 == 0) n = '0;
      model(n, d, er, ez, eo);
      do_div(n, d, i % 3 == 0, r, z, o, lat, bcnt, got);
      check($sformatf("rnd%0d_res", i), 64'(r), 64'(er));
      check($sformatf("rnd%0d_flags", i), {62'd0, z, o}, {62'd0, ez, eo});
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd49);
    end

    nd = 0;
    last = -1;
    next_acc = 0;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      numerator = $urandom;
      denominator = $urandom >> ($urandom % 28);
      if (c >= 147) start = 1'b0;
      @(posedge clk);
      if (start && c == next_acc) begin
        op.n = numerator;
        op.d = denominator;
        q.push_back(op);
        next_acc += 49;
      end
      #1;
      if (done) begin
        nd++;
        if (last >= 0) check("tie_period", 64'(c - last), 64'd49);
        last = c;
        if (q.size() == 0) begin
          check("tie_extra_done", 64'd1, 64'd0);
        end else begin
          op = q.pop_front();
          model(op.n, op.d, er, ez, eo);
          check("tie_res", 64'(result), 64'(er));
          check("tie_flags", {62'd0, dz, ovf}, {62'd0, ez, eo});
        end
      end
      if (c >= 147 && q.size() == 0) break;
    end
    start = 1'b0;
    check("tie_count", 64'(nd), 64'd3);

    @(negedge clk);
    numerator = 32'h0009_0000;
    denominator = 32'h0002_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", {result, done, busy, dz, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("abort_nodone", 64'(nd), 64'd0);
    do_div(32'h0009_0000, 32'h0002_0000, 1'b0, r, z, o, lat, bcnt, got);
    check("post_res", 64'(r), 64'h0004_8000);
    check("post_lat", 64'(lat), 64'd49);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
